// File: rtl/serializer_pkg.sv
// Shared types and helpers for the word-to-UART serializer and its handshake sequencer.
package serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_GAP     = 3'd4
    } state_e;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    // A zero or oversized length means a full word.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
        return (len == 0 || len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/uart_tx_handshake.sv
// Byte-level sequencer: issues tx_start, waits for the UART busy pulse (with ack timeout)
// and inserts the programmable idle gap before the next byte.
module uart_tx_handshake
    import serializer_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = 0,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_req_i,
    input  logic [7:0] byte_i,
    input  logic       tx_busy_i,
    output logic       tx_start_o,
    output logic [7:0] tx_byte_o,
    output logic       byte_err_o,
    output logic       seq_busy_o,
    output logic       byte_take_c_o,
    output logic       byte_done_c_o,
    output logic       slot_end_c_o
);

    localparam int unsigned CW = cnt_width(ACK_TIMEOUT);
    localparam int unsigned GW = cnt_width(GAP_CYCLES);

    state_e          state_q, state_d;
    logic [CW-1:0]   ack_cnt_q, ack_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            err_q, err_d;
    logic            ack_expired_c;
    logic            gap_done_c;

    // The START cycle counts as the first elapsed cycle of the ack window.
    assign ack_expired_c = (32'(ack_cnt_q) + 32'd1) >= ACK_TIMEOUT;
    assign gap_done_c    = 32'(gap_cnt_q) >= GAP_CYCLES;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ack_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            tx_start_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_cnt_q  <= ack_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_start_q <= tx_start_d;
            tx_byte_q  <= tx_byte_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ack_cnt_d     = ack_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        err_d         = 1'b0;
        byte_take_c_o = 1'b0;
        byte_done_c_o = 1'b0;
        slot_end_c_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (byte_req_i) begin
                    byte_take_c_o = 1'b1;
                    state_d       = ST_START;
                end
            end
            ST_START: begin
                ack_cnt_d = CW'(1);
                state_d   = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT_LO;
                end else if (ack_expired_c) begin
                    err_d         = 1'b1;
                    byte_done_c_o = 1'b1;
                    gap_cnt_d     = '0;
                    state_d       = ST_GAP;
                end else if (32'(ack_cnt_q) < ACK_TIMEOUT) begin
                    ack_cnt_d = ack_cnt_q + CW'(1);
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy_i) begin
                    byte_done_c_o = 1'b1;
                    gap_cnt_d     = '0;
                    state_d       = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_done_c) begin
                    slot_end_c_o = 1'b1;
                    if (byte_req_i) begin
                        byte_take_c_o = 1'b1;
                        state_d       = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        tx_start_d = byte_take_c_o;
        tx_byte_d  = byte_take_c_o ? byte_i : tx_byte_q;
    end

    assign tx_start_o = tx_start_q;
    assign tx_byte_o  = tx_byte_q;
    assign byte_err_o = err_q;
    assign seq_busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/word_to_uart_serializer.sv
// Word-level front end: one-word holding register plus shift register feeding the
// byte sequencer, with per-word length and selectable byte order.
module word_to_uart_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned NUM_BYTES   = 10,
    parameter int unsigned MSB_FIRST   = 0,
    parameter int unsigned GAP_CYCLES  = 0,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_BYTES*8-1:0]            in_data,
    input  logic [cnt_width(NUM_BYTES)-1:0]   in_len,
    input  logic                              tx_busy,
    output logic                              tx_start,
    output logic [7:0]                        tx_byte,
    output logic                              active,
    output logic                              word_done,
    output logic                              tx_err
);

    localparam int unsigned DW = NUM_BYTES * 8;
    localparam int unsigned LW = cnt_width(NUM_BYTES);

    logic [DW-1:0] hold_data_q, hold_data_d;
    logic [LW-1:0] hold_len_q, hold_len_d;
    logic          hold_valid_q, hold_valid_d;
    logic [DW-1:0] sh_data_q, sh_data_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          word_done_q, word_done_d;

    logic          accept_c;
    logic          byte_req_c;
    logic          load_c;
    logic [7:0]    next_byte_c;
    logic          take_c;
    logic          done_c;
    logic          slot_end_c;
    logic          seq_busy;

    // LSB-first words are shifted down as bytes go out; MSB-first words index by remaining count.
    function automatic logic [7:0] pick_byte(input logic [DW-1:0] data, input logic [LW-1:0] cnt);
        logic [DW-1:0] shifted;
        if (MSB_FIRST != 0 && cnt != '0) begin
            shifted = data >> (8 * (32'(cnt) - 32'd1));
        end else begin
            shifted = data;
        end
        return shifted[7:0];
    endfunction

    assign accept_c   = in_valid && in_ready;
    assign byte_req_c = hold_valid_q || (rem_q != '0);
    assign load_c     = take_c && (rem_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data_q  <= '0;
            hold_len_q   <= '0;
            hold_valid_q <= 1'b0;
            sh_data_q    <= '0;
            rem_q        <= '0;
            word_done_q  <= 1'b0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_len_q   <= hold_len_d;
            hold_valid_q <= hold_valid_d;
            sh_data_q    <= sh_data_d;
            rem_q        <= rem_d;
            word_done_q  <= word_done_d;
        end
    end

    always_comb begin
        hold_data_d  = hold_data_q;
        hold_len_d   = hold_len_q;
        hold_valid_d = hold_valid_q;
        sh_data_d    = sh_data_q;
        rem_d        = rem_q;
        word_done_d  = slot_end_c && (rem_q == '0);

        if (load_c) begin
            sh_data_d    = hold_data_q;
            rem_d        = hold_len_q;
            hold_valid_d = 1'b0;
        end else if (done_c) begin
            rem_d = rem_q - LW'(1);
            if (MSB_FIRST == 0) begin
                sh_data_d = sh_data_q >> 8;
            end
        end

        if (accept_c) begin
            hold_valid_d = 1'b1;
            hold_data_d  = in_data;
            hold_len_d   = LW'(clamp_len(32'(in_len), NUM_BYTES));
        end

        // A freshly loaded word supplies its first byte straight from the holding register.
        next_byte_c = load_c ? pick_byte(hold_data_q, hold_len_q) : pick_byte(sh_data_q, rem_q);
    end

    uart_tx_handshake #(
        .GAP_CYCLES  (GAP_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_seq (
        .clk           (clk),
        .rst           (rst),
        .byte_req_i    (byte_req_c),
        .byte_i        (next_byte_c),
        .tx_busy_i     (tx_busy),
        .tx_start_o    (tx_start),
        .tx_byte_o     (tx_byte),
        .byte_err_o    (tx_err),
        .seq_busy_o    (seq_busy),
        .byte_take_c_o (take_c),
        .byte_done_c_o (done_c),
        .slot_end_c_o  (slot_end_c)
    );

    assign in_ready  = ~hold_valid_q & ~rst;
    assign active    = hold_valid_q | seq_busy;
    assign word_done = word_done_q;

endmodule

// File: tb/tb_word_to_uart_serializer.sv
// Directed bench: DUT A uses default parameters, DUT B is MSB-first with a 5-cycle gap.
module tb_word_to_uart_serializer;

    localparam int BUSY_A = 20;
    localparam int BUSY_B = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid_a, in_ready_a, tx_busy_a, tx_start_a, active_a, word_done_a, tx_err_a;
    logic [79:0] in_data_a;
    logic [3:0]  in_len_a;
    logic [7:0]  tx_byte_a;
    logic        in_valid_b, in_ready_b, tx_busy_b, tx_start_b, active_b, word_done_b, tx_err_b;
    logic [79:0] in_data_b;
    logic [3:0]  in_len_b;
    logic [7:0]  tx_byte_b;

    word_to_uart_serializer u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .in_len(in_len_a), .tx_busy(tx_busy_a),
        .tx_start(tx_start_a), .tx_byte(tx_byte_a), .active(active_a),
        .word_done(word_done_a), .tx_err(tx_err_a)
    );

    word_to_uart_serializer #(.NUM_BYTES(10), .MSB_FIRST(1), .GAP_CYCLES(5), .ACK_TIMEOUT(16)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .in_len(in_len_b), .tx_busy(tx_busy_b),
        .tx_start(tx_start_b), .tx_byte(tx_byte_b), .active(active_b),
        .word_done(word_done_b), .tx_err(tx_err_b)
    );

    // UART models and monitors; a fall edge is the posedge that first samples busy low.
    logic [7:0] bytes_a[$];
    int         gaps_a[$];
    int         errs_a[$];
    int         starts_a = 0, wd_cnt_a = 0, wd_cyc_a = 0, busy_cnt_a = 0, last_fall_a = 0;
    bit         fall_seen_a = 0, uart_dead_a = 0;
    logic [7:0] bytes_b[$];
    int         gaps_b[$];
    int         wd_cnt_b = 0, wd_cyc_b = 0, busy_cnt_b = 0, last_fall_b = 0, errs_b = 0;
    bit         fall_seen_b = 0;

    initial tx_busy_a = 1'b0;
    initial tx_busy_b = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt_a = 0;
            tx_busy_a  = 1'b0;
        end else begin
            if (tx_start_a) begin
                bytes_a.push_back(tx_byte_a);
                starts_a++;
                if (fall_seen_a) gaps_a.push_back(cyc - last_fall_a);
                fall_seen_a = 0;
                if (!uart_dead_a) begin
                    busy_cnt_a = BUSY_A;
                    tx_busy_a  = 1'b1;
                end
            end else if (busy_cnt_a > 0) begin
                busy_cnt_a--;
                if (busy_cnt_a == 0) begin
                    tx_busy_a   = 1'b0;
                    last_fall_a = cyc + 1;
                    fall_seen_a = 1;
                end
            end
            if (word_done_a) begin
                wd_cnt_a++;
                wd_cyc_a = cyc;
            end
            if (tx_err_a) errs_a.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt_b = 0;
            tx_busy_b  = 1'b0;
        end else begin
            if (tx_start_b) begin
                bytes_b.push_back(tx_byte_b);
                if (fall_seen_b) gaps_b.push_back(cyc - last_fall_b);
                fall_seen_b = 0;
                busy_cnt_b  = BUSY_B;
                tx_busy_b   = 1'b1;
            end else if (busy_cnt_b > 0) begin
                busy_cnt_b--;
                if (busy_cnt_b == 0) begin
                    tx_busy_b   = 1'b0;
                    last_fall_b = cyc + 1;
                    fall_seen_b = 1;
                end
            end
            if (word_done_b) begin
                wd_cnt_b++;
                wd_cyc_b = cyc;
            end
            if (tx_err_b) errs_b++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_a();
        bytes_a.delete();
        gaps_a.delete();
        errs_a.delete();
        starts_a    = 0;
        wd_cnt_a    = 0;
        fall_seen_a = 0;
    endtask

    task automatic send_a(input logic [79:0] d, input logic [3:0] len, output int acc);
        in_data_a  = d;
        in_len_a   = len;
        in_valid_a = 1'b1;
        acc        = -1;
        for (int n = 0; n < 2000; n++) begin
            if (in_ready_a) begin
                acc = cyc + 1;
                break;
            end
            tick();
        end
        if (acc >= 0) tick();
        in_valid_a = 1'b0;
        chk("accept_a", 32'(acc >= 0), 32'd1);
    endtask

    task automatic send_b(input logic [79:0] d, input logic [3:0] len);
        int acc;
        in_data_b  = d;
        in_len_b   = len;
        in_valid_b = 1'b1;
        acc        = -1;
        for (int n = 0; n < 2000; n++) begin
            if (in_ready_b) begin
                acc = cyc + 1;
                break;
            end
            tick();
        end
        if (acc >= 0) tick();
        in_valid_b = 1'b0;
        chk("accept_b", 32'(acc >= 0), 32'd1);
    endtask

    initial begin
        int acc;
        int first_start;
        int viol;
        bit seen;

        in_valid_a = 1'b0; in_data_a = '0; in_len_a = '0;
        in_valid_b = 1'b0; in_data_b = '0; in_len_b = '0;

        // Reset values
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready_a), 32'd0);
        chk("rst_tx_start", 32'(tx_start_a), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte_a), 32'h00);
        chk("rst_active", 32'(active_a), 32'd0);
        chk("rst_word_done", 32'(word_done_a), 32'd0);
        chk("rst_tx_err", 32'(tx_err_a), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready_a", 32'(in_ready_a), 32'd1);
        chk("rel_in_ready_b", 32'(in_ready_b), 32'd1);
        tick();

        // Full default word "0123456789", in_len=0 means all ten bytes
        clear_a();
        send_a(80'h39_38_37_36_35_34_33_32_31_30, 4'd0, acc);
        for (int n = 0; n < 800 && wd_cnt_a < 1; n++) tick();
        repeat (3) tick();
        chk("t1_word_done_cnt", 32'(wd_cnt_a), 32'd1);
        chk("t1_byte_cnt", 32'(bytes_a.size()), 32'd10);
        for (int i = 0; i < 10; i++) chk("t1_byte", 32'(bytes_a[i]), 32'h30 + 32'(i));
        chk("t1_gap_cnt", 32'(gaps_a.size()), 32'd9);
        for (int i = 0; i < gaps_a.size(); i++) chk("t1_gap", 32'(gaps_a[i]), 32'd1);
        chk("t1_done_after_fall", 32'(wd_cyc_a - last_fall_a), 32'd1);
        chk("t1_active_idle", 32'(active_a), 32'd0);

        // First-byte latency: accept at E0, tx_start visible after E0+1
        clear_a();
        send_a(80'h12_11, 4'd2, acc);
        first_start = -1;
        for (int n = 0; n < 10 && first_start < 0; n++) begin
            if (tx_start_a) first_start = cyc;
            else tick();
        end
        chk("lat_first_start", 32'(first_start - acc), 32'd1);
        chk("lat_first_byte", 32'(tx_byte_a), 32'h11);

        // Back-to-back: second word waits in the holding register until the handoff
        send_a(80'h22_21, 4'd2, acc);
        viol = 0;
        seen = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            if (word_done_a) begin
                seen = 1;
                chk("b2b_ready_at_handoff", 32'(in_ready_a), 32'd1);
                chk("b2b_start_with_done", 32'(tx_start_a), 32'd1);
                chk("b2b_first_byte_w2", 32'(tx_byte_a), 32'h21);
            end else begin
                if (in_ready_a) viol++;
                tick();
            end
        end
        chk("b2b_done_seen", 32'(seen), 32'd1);
        chk("b2b_ready_low_while_queued", 32'(viol), 32'd0);
        for (int n = 0; n < 300 && wd_cnt_a < 2; n++) tick();
        repeat (3) tick();
        chk("b2b_word_done_cnt", 32'(wd_cnt_a), 32'd2);
        chk("b2b_byte_cnt", 32'(bytes_a.size()), 32'd4);
        chk("b2b_byte0", 32'(bytes_a[0]), 32'h11);
        chk("b2b_byte1", 32'(bytes_a[1]), 32'h12);
        chk("b2b_byte2", 32'(bytes_a[2]), 32'h21);
        chk("b2b_byte3", 32'(bytes_a[3]), 32'h22);
        for (int i = 0; i < gaps_a.size(); i++) chk("b2b_gap", 32'(gaps_a[i]), 32'd1);

        // Dead UART: ack timeout on every byte, word still completes
        clear_a();
        uart_dead_a = 1;
        send_a(80'h63_62_61, 4'd3, acc);
        for (int n = 0; n < 300 && wd_cnt_a < 1; n++) tick();
        repeat (3) tick();
        chk("to_err_cnt", 32'(errs_a.size()), 32'd3);
        chk("to_err_gap1", 32'(errs_a[1] - errs_a[0]), 32'd17);
        chk("to_err_gap2", 32'(errs_a[2] - errs_a[1]), 32'd17);
        chk("to_word_done_cnt", 32'(wd_cnt_a), 32'd1);
        chk("to_done_after_err", 32'(wd_cyc_a - errs_a[2]), 32'd1);
        chk("to_active_idle", 32'(active_a), 32'd0);
        uart_dead_a = 0;

        // Reset mid-word after four bytes have completed
        clear_a();
        send_a(80'h4A_49_48_47_46_45_44_43_42_41, 4'd10, acc);
        for (int n = 0; n < 400 && starts_a < 5; n++) tick();
        chk("mid_bytes_before_rst", 32'(starts_a), 32'd5);
        rst = 1'b1;
        #1;
        chk("mid_in_ready_in_rst", 32'(in_ready_a), 32'd0);
        tick();
        chk("mid_tx_start", 32'(tx_start_a), 32'd0);
        chk("mid_tx_byte", 32'(tx_byte_a), 32'h00);
        chk("mid_active", 32'(active_a), 32'd0);
        chk("mid_word_done", 32'(word_done_a), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_in_ready_after", 32'(in_ready_a), 32'd1);
        repeat (40) tick();
        chk("mid_no_word_done", 32'(wd_cnt_a), 32'd0);
        clear_a();
        send_a(80'h62_61, 4'd2, acc);
        for (int n = 0; n < 300 && wd_cnt_a < 1; n++) tick();
        repeat (3) tick();
        chk("post_rst_cnt", 32'(bytes_a.size()), 32'd2);
        chk("post_rst_byte0", 32'(bytes_a[0]), 32'h61);
        chk("post_rst_byte1", 32'(bytes_a[1]), 32'h62);

        // DUT B: MSB-first short word with a 5-cycle gap
        bytes_b.delete();
        gaps_b.delete();
        fall_seen_b = 0;
        wd_cnt_b    = 0;
        send_b(80'h55_55_55_55_55_55_55_43_42_41, 4'd3);
        for (int n = 0; n < 300 && wd_cnt_b < 1; n++) tick();
        repeat (3) tick();
        chk("msb_byte_cnt", 32'(bytes_b.size()), 32'd3);
        chk("msb_byte0", 32'(bytes_b[0]), 32'h43);
        chk("msb_byte1", 32'(bytes_b[1]), 32'h42);
        chk("msb_byte2", 32'(bytes_b[2]), 32'h41);
        chk("gap5_cnt", 32'(gaps_b.size()), 32'd2);
        for (int i = 0; i < gaps_b.size(); i++) chk("gap5_fall_to_start", 32'(gaps_b[i]), 32'd6);
        chk("gap5_done_after_fall", 32'(wd_cyc_b - last_fall_b), 32'd6);
        chk("msb_word_done_cnt", 32'(wd_cnt_b), 32'd1);

        // DUT B: oversized in_len clamps to a full word, top byte first
        bytes_b.delete();
        gaps_b.delete();
        fall_seen_b = 0;
        wd_cnt_b    = 0;
        send_b(80'hA9_A8_A7_A6_A5_A4_A3_A2_A1_A0, 4'd15);
        for (int n = 0; n < 600 && wd_cnt_b < 1; n++) tick();
        repeat (3) tick();
        chk("clamp_byte_cnt", 32'(bytes_b.size()), 32'd10);
        chk("clamp_first", 32'(bytes_b[0]), 32'hA9);
        chk("clamp_last", 32'(bytes_b[9]), 32'hA0);
        chk("clamp_active_idle", 32'(active_b), 32'd0);
        chk("b_no_err", 32'(errs_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
